control_unit: RTL
=================

Name: control_unit

Overview:
- Multicycle FSM that sequences the CPU datapath: PC, memory, IR, register bank, A/B, ALU, ALUOut, MDR and EPC.
- Decodes opcode/funct from the IR and drives every write enable, mux select and ALU operation for each cycle.
- Handles invalid-opcode and arithmetic-overflow exceptions, vectoring through a handler byte read from memory.
- Sits beside the datapath inside the top-level cpu; pure controller, no datapath storage of its own beyond state and counters.

Parameters:
- MEM_WAIT, 1, extra wait cycles inserted after every memory read before data is sampled (0..7).
- EXC_OPC_ADDR, 253, byte address holding the invalid-opcode handler address.
- EXC_OVF_ADDR, 254, byte address holding the overflow handler address.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- overflow  in  1  ALU overflow flag
- eq  in  1  ALU A==B flag
- PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl, MDRWrite, EPCWrite  out  1 each  write enables
- IorD  out  2  0=PC, 1=ALUOut, 2=EXC_OPC_ADDR, 3=EXC_OVF_ADDR
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  0=B, 1=const 4, 2=sext(imm), 3=sext(imm)<<2
- ALU_Control  out  3  ula32 op: 000 pass A, 001 add, 010 sub, 011 and
- RegDst  out  2  0=rt, 1=rd, 2=$31
- DataSrc  out  2  0=ALUOut, 1=MDR, 2=PC
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=sext8(memory byte)
- state_out  out  5  current state encoding, debug only

Behaviour:
- Reset (async assert, sync release): state=FETCH0, wait counter=0, ovf latch=0; all enables 0, all selects 0, ALU_Control=000. First active edge after release executes FETCH0.
- Outputs are Moore (decoded from state) except PCWrite in BRANCH, which is gated by eq.
- Memory read sequence: issue state, then MEM_WAIT wait states holding address/selects, then sample state. Counter reloads on entry to each read; MEM_WAIT=0 means issue is followed directly by sample.
- FETCH0: IorD=0; ALUSrcA=0, ALUSrcB=1, add. -> FETCH_W.
- FETCH_W: wait. -> FETCH2.
- FETCH2: IRWrite=1; PCWrite=1, PCSource=0, so PC<=PC+4. -> DECODE.
- DECODE: ABWrite=1; ALUOutControl=1 with PC + sext(imm)<<2 (branch target). Dispatch on opcode:
  - 0x00 R -> EXEC_R if funct in {0x20 add, 0x22 sub, 0x24 and}, else EXC0 code OPC
  - 0x08 addi -> EXEC_I
  - 0x23 lw / 0x2B sw -> ADDR
  - 0x04 beq -> BRANCH
  - 0x02 j -> JUMP
  - other -> EXC0 code OPC
- EXEC_R: ALUSrcA=1, ALUSrcB=0, op from funct; ALUOutControl=1; ovf latch<=overflow&(add|sub). -> WB_R.
- WB_R: if latch set -> EXC0 code OVF with no RegWrite; else RegWrite=1, RegDst=1, DataSrc=0. -> FETCH0.
- EXEC_I / WB_I: same as R path with ALUSrcB=2, add, RegDst=0.
- ADDR: A+sext(imm) -> ALUOut. -> MEM_RD if lw, MEM_WR if sw.
- MEM_RD(IorD=1) -> MEM_W -> MEM_RD2 (MDRWrite=1) -> WB_LW (RegWrite, RegDst=0, DataSrc=1) -> FETCH0.
- MEM_WR: IorD=1, MemWrite=1 for exactly one cycle. -> FETCH0.
- BRANCH: ALUSrcA=1, ALUSrcB=0, sub; PCWrite=eq, PCSource=1. -> FETCH0.
- JUMP: PCWrite=1, PCSource=2. -> FETCH0.
- EXC0: EPC<=PC-4 (ALUSrcA=0, ALUSrcB=1, sub, EPCWrite=1); IorD=2 or 3 per code. -> EXC_W -> EXC2.
- EXC2: PCWrite=1, PCSource=3, IorD held. -> FETCH0.
- Never more than one of RegWrite/MemWrite/IRWrite asserted in a cycle.
- Unused state encodings -> FETCH0.
- Reset mid-instruction aborts immediately; no partial write completes after assertion.

Optional Feature:
- JAL_EN defined: opcode 0x03 jal decodes to JAL state: RegWrite=1, RegDst=2, DataSrc=2 (PC already +4), PCWrite=1, PCSource=2, single cycle -> FETCH0.
- JAL_EN undefined: 0x03 raises the invalid-opcode exception.

Test Plan:
- Reset low mid-EXEC_R, release -> state_out=FETCH0, all enables 0; after FETCH2, PC advanced by exactly 4.
- add with MEM_WAIT=1 -> 6 cycles FETCH0..WB_R; RegWrite high only in WB_R with RegDst=1.
- add 0x7FFFFFFF+1 -> no RegWrite; EPCWrite in EXC0 with IorD=3; PCWrite in EXC2 with PCSource=3.
- beq, eq=1 -> PCWrite=1, PCSource=1; eq=0 -> PCWrite=0; both return to FETCH0.
- lw then sw, MEM_WAIT=2 -> two wait cycles in MEM_W; MDRWrite one cycle; MemWrite exactly one cycle, IorD=1.
- opcode 0x3F, and opcode 0x03 without JAL_EN -> EXC0 with IorD=2; with JAL_EN, 0x03 -> RegDst=2, DataSrc=2, PCSource=2.

Source files
------------

// File: rtl/control_unit_if.sv
// Control bundle between the multicycle controller and the datapath: IR fields
// and ALU flags in, every write enable and mux select out.
interface control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       eq;

  logic       PCWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ABWrite;
  logic       ALUOutControl;
  logic       MDRWrite;
  logic       EPCWrite;
  logic [1:0] IorD;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALU_Control;
  logic [1:0] RegDst;
  logic [1:0] DataSrc;
  logic [1:0] PCSource;
  logic [4:0] state_out;

  modport master (
    input  opcode, funct, overflow, eq,
    output PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl,
           MDRWrite, EPCWrite, IorD, ALUSrcA, ALUSrcB, ALU_Control,
           RegDst, DataSrc, PCSource, state_out
  );

  modport slave (
    output opcode, funct, overflow, eq,
    input  PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl,
           MDRWrite, EPCWrite, IorD, ALUSrcA, ALUSrcB, ALU_Control,
           RegDst, DataSrc, PCSource, state_out
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle CPU controller: fetch/decode/execute sequencing with memory wait
// states and exception vectoring. Define JAL_EN to add the jal instruction.
module control_unit #(
  parameter int MEM_WAIT     = 1,
  parameter int EXC_OPC_ADDR = 253,
  parameter int EXC_OVF_ADDR = 254
) (
  input logic            clock,
  input logic            reset,
  control_unit_if.master bus
);

  if (MEM_WAIT < 0 || MEM_WAIT > 7 || EXC_OPC_ADDR < 0 || EXC_OPC_ADDR > 255 ||
      EXC_OVF_ADDR < 0 || EXC_OVF_ADDR > 255 || EXC_OPC_ADDR == EXC_OVF_ADDR) begin : g_bad_config
    $error("control_unit: MEM_WAIT must be 0..7 and handler addresses distinct bytes");
  end

  typedef enum logic [4:0] {
    FETCH0  = 5'd0,  FETCH_W = 5'd1,  FETCH2  = 5'd2,  DECODE  = 5'd3,
    EXEC_R  = 5'd4,  WB_R    = 5'd5,  EXEC_I  = 5'd6,  WB_I    = 5'd7,
    ADDR    = 5'd8,  MEM_RD  = 5'd9,  MEM_W   = 5'd10, MEM_RD2 = 5'd11,
    WB_LW   = 5'd12, MEM_WR  = 5'd13, BRANCH  = 5'd14, JUMP    = 5'd15,
    EXC0    = 5'd16, EXC_W   = 5'd17, EXC2    = 5'd18, JAL     = 5'd19
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
  localparam logic [2:0] WAIT_RELOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  state_t     state, next_state;
  logic [2:0] wait_cnt;
  logic       ovf_latch;
  logic       exc_is_ovf;
  logic       wait_done;
  logic       funct_ok;
  logic [2:0] funct_op;
  logic [1:0] exc_iord;

  assign wait_done = (wait_cnt == 3'd0);
  assign funct_ok  = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) || (bus.funct == FN_AND);
  assign exc_iord  = exc_is_ovf ? 2'd3 : 2'd2;
  assign bus.state_out = state;

  always_comb begin
    funct_op = ALU_ADD;
    case (bus.funct)
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      default: funct_op = ALU_ADD;
    endcase
  end

  // Wait counter reloads in every read-issue state; the exception code is
  // cleared in DECODE and only set when a writeback stage diverts to EXC0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= FETCH0;
      wait_cnt   <= 3'd0;
      ovf_latch  <= 1'b0;
      exc_is_ovf <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH0 || state == MEM_RD || state == EXC0)
        wait_cnt <= WAIT_RELOAD;
      else if (!wait_done && (state == FETCH_W || state == MEM_W || state == EXC_W))
        wait_cnt <= wait_cnt - 3'd1;
      if (state == EXEC_R)
        ovf_latch <= bus.overflow & ((bus.funct == FN_ADD) || (bus.funct == FN_SUB));
      else if (state == EXEC_I)
        ovf_latch <= bus.overflow;
      if (state == DECODE)
        exc_is_ovf <= 1'b0;
      else if (state == WB_R || state == WB_I)
        exc_is_ovf <= 1'b1;
    end
  end

  always_comb begin
    next_state = FETCH0;
    case (state)
      FETCH0:  next_state = (MEM_WAIT == 0) ? FETCH2 : FETCH_W;
      FETCH_W: next_state = wait_done ? FETCH2 : FETCH_W;
      FETCH2:  next_state = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:         next_state = funct_ok ? EXEC_R : EXC0;
          OP_ADDI:      next_state = EXEC_I;
          OP_LW, OP_SW: next_state = ADDR;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
`ifdef JAL_EN
          OP_JAL:       next_state = JAL;
`endif
          default:      next_state = EXC0;
        endcase
      end
      EXEC_R:  next_state = WB_R;
      WB_R:    next_state = ovf_latch ? EXC0 : FETCH0;
      EXEC_I:  next_state = WB_I;
      WB_I:    next_state = ovf_latch ? EXC0 : FETCH0;
      ADDR:    next_state = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  next_state = (MEM_WAIT == 0) ? MEM_RD2 : MEM_W;
      MEM_W:   next_state = wait_done ? MEM_RD2 : MEM_W;
      MEM_RD2: next_state = WB_LW;
      EXC0:    next_state = (MEM_WAIT == 0) ? EXC2 : EXC_W;
      EXC_W:   next_state = wait_done ? EXC2 : EXC_W;
      default: next_state = FETCH0;
    endcase
  end

  // Everything is decoded from state except the branch PC write; holding
  // reset forces all controls to their idle value.
  always_comb begin
    bus.PCWrite = 1'b0;  bus.MemWrite = 1'b0; bus.IRWrite = 1'b0;  bus.RegWrite = 1'b0;
    bus.ABWrite = 1'b0;  bus.ALUOutControl = 1'b0; bus.MDRWrite = 1'b0; bus.EPCWrite = 1'b0;
    bus.IorD = 2'd0;     bus.ALUSrcA = 1'b0;  bus.ALUSrcB = 2'd0;  bus.ALU_Control = 3'b000;
    bus.RegDst = 2'd0;   bus.DataSrc = 2'd0;  bus.PCSource = 2'd0;
    if (reset) begin
      case (state)
        FETCH0, FETCH_W: begin bus.ALUSrcB = 2'd1; bus.ALU_Control = ALU_ADD; end
        FETCH2: begin
          bus.IRWrite = 1'b1; bus.PCWrite = 1'b1;
          bus.ALUSrcB = 2'd1; bus.ALU_Control = ALU_ADD;
        end
        DECODE: begin
          bus.ABWrite = 1'b1; bus.ALUOutControl = 1'b1;
          bus.ALUSrcB = 2'd3; bus.ALU_Control = ALU_ADD;
        end
        EXEC_R: begin
          bus.ALUSrcA = 1'b1; bus.ALU_Control = funct_op; bus.ALUOutControl = 1'b1;
        end
        WB_R: if (!ovf_latch) begin bus.RegWrite = 1'b1; bus.RegDst = 2'd1; end
        EXEC_I, ADDR: begin
          bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'd2;
          bus.ALU_Control = ALU_ADD; bus.ALUOutControl = 1'b1;
        end
        WB_I:          if (!ovf_latch) bus.RegWrite = 1'b1;
        MEM_RD, MEM_W: bus.IorD = 2'd1;
        MEM_RD2: begin bus.IorD = 2'd1; bus.MDRWrite = 1'b1; end
        WB_LW:   begin bus.RegWrite = 1'b1; bus.DataSrc = 2'd1; end
        MEM_WR:  begin bus.IorD = 2'd1; bus.MemWrite = 1'b1; end
        BRANCH: begin
          bus.ALUSrcA = 1'b1; bus.ALU_Control = ALU_SUB;
          bus.PCWrite = bus.eq; bus.PCSource = 2'd1;
        end
        JUMP:    begin bus.PCWrite = 1'b1; bus.PCSource = 2'd2; end
        EXC0: begin
          bus.EPCWrite = 1'b1; bus.ALUSrcB = 2'd1;
          bus.ALU_Control = ALU_SUB; bus.IorD = exc_iord;
        end
        EXC_W:   bus.IorD = exc_iord;
        EXC2:    begin bus.IorD = exc_iord; bus.PCWrite = 1'b1; bus.PCSource = 2'd3; end
`ifdef JAL_EN
        JAL: begin
          bus.RegWrite = 1'b1; bus.RegDst = 2'd2; bus.DataSrc = 2'd2;
          bus.PCWrite = 1'b1; bus.PCSource = 2'd2;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
